bitrev_serial_pal: RTL and testbench

Serial-input bit-reversal and palindrome checker with runtime-selectable word length. It collects a stream of bits under a valid qualifier, then produces the assembled word, its reversal and a palindrome flag, announced by a one-cycle `done` strobe. It also keeps a saturating count of palindromic words. It is the sequential, length-programmable successor to the combinational fixed-width bit reverser, and sits between a serial front end and the word-level checking logic.

---
 rtl/bitrev_serial_pal.sv | 118 +++++++++++
 tb/tb_bitrev_serial_pal.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bitrev_serial_pal.sv
// Serial bit collector with runtime word length: produces the word, its len-bit
// reversal, a palindrome flag and a saturating count of palindromic words.
module bitrev_serial_pal #(
  parameter  int unsigned N  = 8,
  parameter  int unsigned CW = 16,
  localparam int unsigned LW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          bit_in,
  input  logic          bit_valid,
  input  logic          cnt_clr,
  output logic          busy,
  output logic          done,
  output logic          len_err,
  output logic [N-1:0]  word,
  output logic [N-1:0]  rev,
  output logic          palind,
  output logic [CW-1:0] pal_count
);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t        state, state_nx;
  logic [LW-1:0] len_q, k;
  logic [N-1:0]  sreg, full_rev, rev_c;
  logic          len_ok_c, load_c, shift_c, check_c, len_err_c, palind_c;

  // Next-state and control decode
  always_comb begin
    state_nx  = state;
    load_c    = 1'b0;
    shift_c   = 1'b0;
    check_c   = 1'b0;
    len_err_c = 1'b0;
    len_ok_c  = (len != '0) && (len <= LW'(N));
    case (state)
      IDLE: begin
        if (start) begin
          if (len_ok_c) begin
            load_c   = 1'b1;
            state_nx = SHIFT;
          end else begin
            len_err_c = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          shift_c = 1'b1;
          if (k == len_q - LW'(1)) state_nx = CHECK;
        end
      end
      CHECK: begin
        check_c  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Full-width reversal shifted down so only the low len bits survive;
  // the shift register is zero above len, so the upper result bits are zero.
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      full_rev[i] = sreg[N-1-i];
    end
    rev_c    = full_rev >> (LW'(N) - len_q);
    palind_c = (sreg == rev_c);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      len_err   <= 1'b0;
      len_q     <= '0;
      k         <= '0;
      sreg      <= '0;
      word      <= '0;
      rev       <= '0;
      palind    <= 1'b0;
      pal_count <= '0;
    end else begin
      busy    <= (state_nx != IDLE);
      done    <= check_c;
      len_err <= len_err_c;
      if (load_c) begin
        len_q <= len;
        k     <= '0;
        sreg  <= '0;
      end
      if (shift_c) begin
        sreg <= sreg | (N'(bit_in) << k);
        k    <= k + LW'(1);
      end
      if (check_c) begin
        word   <= sreg;
        rev    <= rev_c;
        palind <= palind_c;
      end
      if (cnt_clr) begin
        pal_count <= '0;
      end else if (check_c && palind_c && (pal_count != '1)) begin
        pal_count <= pal_count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bitrev_serial_pal.sv
// Directed bench for bitrev_serial_pal with a scoreboard of expected results;
// a second instance with a 2-bit counter exercises saturation on the same stream.
module tb_bitrev_serial_pal;

  localparam int unsigned N  = 8;
  localparam int unsigned LW = 4;

  logic          clk, rst, start, bit_in, bit_valid, cnt_clr;
  logic [LW-1:0] len;
  logic          busy, done, len_err, palind;
  logic [N-1:0]  word, rev;
  logic [15:0]   pal_count;
  logic          busy2, done2, len_err2, palind2;
  logic [N-1:0]  word2, rev2;
  logic [1:0]    pal_count2;

  bitrev_serial_pal dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .bit_in(bit_in),
    .bit_valid(bit_valid), .cnt_clr(cnt_clr), .busy(busy), .done(done),
    .len_err(len_err), .word(word), .rev(rev), .palind(palind),
    .pal_count(pal_count)
  );

  bitrev_serial_pal #(.CW(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .len(len), .bit_in(bit_in),
    .bit_valid(bit_valid), .cnt_clr(cnt_clr), .busy(busy2), .done(done2),
    .len_err(len_err2), .word(word2), .rev(rev2), .palind(palind2),
    .pal_count(pal_count2)
  );

  typedef struct {
    logic [7:0]  word;
    logic [7:0]  rev;
    logic        palind;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         cnt_m  = 0;
  int         cnt2_m = 0;
  logic [7:0] last_word = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction; ends on the negedge where done is observed.
  task automatic run_word(input int l, input logic [7:0] bits, input bit b2b,
                          input int stall_at, input bit clr);
    exp_t e;
    int   cyc;
    if (!b2b) begin
      @(negedge clk);
      check("done_low_before_start", 32'(done), 0);
    end
    start = 1'b1;
    len   = LW'(l);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    for (int i = 0; i < l; i++) begin
      if (i == stall_at) begin
        bit_valid = 1'b0;
        start     = 1'b1;
        len       = 4'd3;
        repeat (3) @(negedge clk);
        start = 1'b0;
        check("busy_in_stall", 32'(busy), 1);
      end
      bit_valid = 1'b1;
      bit_in    = bits[i];
      @(negedge clk);
      bit_valid = 1'b0;
      bit_in    = 1'b0;
    end
    e.word = '0;
    e.rev  = '0;
    for (int i = 0; i < l; i++) begin
      e.word[i] = bits[i];
      e.rev[i]  = bits[l-1-i];
    end
    e.palind = (e.word == e.rev);
    if (clr) begin
      cnt_m  = 0;
      cnt2_m = 0;
    end else if (e.palind) begin
      if (cnt_m < 65535) cnt_m++;
      if (cnt2_m < 3) cnt2_m++;
    end
    e.cnt  = 16'(cnt_m);
    e.cnt2 = 2'(cnt2_m);
    sb.push_back(e);
    cnt_clr = clr;
    cyc = 0;
    while (done !== 1'b1 && cyc < 6) begin
      @(negedge clk);
      cyc++;
    end
    cnt_clr = 1'b0;
    check("done_latency", 32'(cyc), 1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("word", 32'(word), 32'(e.word));
      check("rev", 32'(rev), 32'(e.rev));
      check("palind", 32'(palind), 32'(e.palind));
      check("pal_count", 32'(pal_count), 32'(e.cnt));
      check("pal_count_cw2", 32'(pal_count2), 32'(e.cnt2));
      check("busy_at_done", 32'(busy), 0);
      last_word = e.word;
    end
  endtask

  task automatic bad_len(input logic [LW-1:0] l);
    @(negedge clk);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
    check("len_err_pulse", 32'(len_err), 1);
    check("busy_len_err", 32'(busy), 0);
    @(negedge clk);
    check("len_err_one_cycle", 32'(len_err), 0);
    check("word_held", 32'(word), 32'(last_word));
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_len_err", 32'(len_err), 0);
    check("rst_word", 32'(word), 0);
    check("rst_rev", 32'(rev), 0);
    check("rst_palind", 32'(palind), 0);
    check("rst_pal_count", 32'(pal_count), 0);
    check("rst_pal_count_cw2", 32'(pal_count2), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; bit_in = 1'b0; bit_valid = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    run_word(8, 8'hAD, 1'b0, -1, 1'b0);   // non-palindrome
    run_word(8, 8'h81, 1'b0, 4, 1'b0);    // palindrome, stall and ignored start mid-stream
    run_word(5, 8'h1B, 1'b0, -1, 1'b0);
    run_word(4, 8'h01, 1'b0, -1, 1'b0);
    run_word(1, 8'h00, 1'b0, -1, 1'b0);

    bad_len(4'd0);
    bad_len(4'd9);

    run_word(8, 8'hFF, 1'b0, -1, 1'b0);   // fourth palindrome: 2-bit counter saturates
    run_word(5, 8'h11, 1'b1, -1, 1'b0);   // start in done cycle
    run_word(3, 8'h05, 1'b0, -1, 1'b1);   // clear coincides with increment

    // Reset after 3 of 8 bits
    @(negedge clk);
    start = 1'b1;
    len   = 4'd8;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      @(negedge clk);
    end
    bit_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs();
    cnt_m  = 0;
    cnt2_m = 0;
    sb.delete();
    run_word(8, 8'hAD, 1'b0, -1, 1'b0);
    run_word(8, 8'h3C, 1'b0, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
